// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  localparam logic [31:0] NOP_INST        = 32'h00000013;
  localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-cycle counter that flags a hung memory access
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // A zero TIMEOUT disables expiry entirely.
  assign expire = (TIMEOUT > 0) && (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  arb_state_t state;
  logic       drop;
  logic       expire;
  logic       busy;
  logic       abort;
  logic       finish;

  assign busy   = (state != IDLE);
  // A ready arriving in the expiry cycle wins over the timeout.
  assign abort  = busy & expire & ~mem_ready;
  assign finish = busy & (mem_ready | abort);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (~busy),
    .en     (busy & ~mem_ready),
    .expire (expire)
  );

  assign if_done   = (state == FETCH) & (mem_ready | abort) & ~drop & ~if_flush;
  assign dm_done   = (state == DATA) & (mem_ready | abort);
  assign if_rdata  = mem_ready ? mem_rdata : DATA_W'(NOP_INST);
  assign dm_rdata  = mem_ready ? mem_rdata : '0;
  assign stall_mem = dm_req & ~dm_done;
  assign stall_if  = (if_req & ~if_done) | stall_mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      bus_err   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (dm_req) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
          end else if (if_req) begin
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wstrb <= '0;
          end
        end
        FETCH, DATA: begin
          if (finish) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= abort;
            drop    <= 1'b0;
          end else if (state == FETCH && if_flush) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with random traffic
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_if, stall_mem, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} issue_t;
  typedef struct {bit chk; logic [31:0] data;} resp_t;

  issue_t issue_q[$];
  resp_t  if_q[$];
  resp_t  dm_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] env_mem[int];

  int  errors = 0, checks = 0;
  int  err_pulses = 0, exp_err_pulses = 0;
  int  lat = 0;
  bit  hang = 1'b0;
  bit  resp_en = 1'b1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h00130000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, wd, input logic [3:0] ws);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    int k = int'(a >> 2);
    return env_mem.exists(k) ? env_mem[k] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers each access after lat wait cycles, or never while hang is set.
  initial begin
    int wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ready = 1'b0;
        if (mem_req && !hang) begin
          if (wcnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = env_rd(mem_addr);
            if (mem_we) env_mem[int'(mem_addr >> 2)] = merge(env_rd(mem_addr), mem_wdata, mem_wstrb);
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  // Monitor: issue order/contents, completion data, error pulses.
  initial begin
    logic   prev_req = 1'b0;
    issue_t e;
    resp_t  r;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (issue_q.size() == 0) begin
            chk("issue_unexpected_addr", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = issue_q.pop_front();
            chk("issue_addr", mem_addr, e.addr);
            chk("issue_we", 32'(mem_we), 32'(e.we));
            chk("issue_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
            if (e.we) chk("issue_wdata", mem_wdata, e.wdata);
          end
        end
        prev_req = mem_req;
        if (if_done) begin
          if (if_q.size() == 0) chk("if_done_unexpected", 32'(if_done), 32'd0);
          else begin
            r = if_q.pop_front();
            if (r.chk) chk("if_rdata", if_rdata, r.data);
          end
        end
        if (dm_done) begin
          if (dm_q.size() == 0) chk("dm_done_unexpected", 32'(dm_done), 32'd0);
          else begin
            r = dm_q.pop_front();
            if (r.chk) chk("dm_rdata", dm_rdata, r.data);
          end
        end
        if (bus_err) err_pulses++;
      end
    end
  end

  task automatic run_access(input bit do_if, input bit do_dm, input bit we,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input int flush_at, input bit tmo, input int l);
    issue_t is;
    resp_t  r;
    int cyc = 0, fcyc = 0, done_cyc = 0;
    bit pend_if = do_if, pend_dm = do_dm, dm_before;
    lat  = l;
    hang = tmo;
    if (do_dm) begin
      is = '{we, da, wd, ws};
      issue_q.push_back(is);
      r.chk  = tmo || !we;
      r.data = tmo ? 32'h0 : ref_rd(da);
      dm_q.push_back(r);
      if (tmo) exp_err_pulses++;
      else if (we) ref_mem[int'(da >> 2)] = merge(ref_rd(da), wd, ws);
    end
    if (do_if) begin
      is = '{1'b0, ia, 32'h0, 4'h0};
      issue_q.push_back(is);
      if (tmo) exp_err_pulses++;
      if (flush_at == 0) begin
        r.chk  = 1'b1;
        r.data = tmo ? NOP_INST : ref_rd(ia);
        if_q.push_back(r);
      end
    end
    @(negedge clk); #2;
    if_req = do_if; if_addr = ia;
    dm_req = do_dm; dm_we = we; dm_addr = da; dm_wdata = wd; dm_wstrb = ws;
    while ((pend_if || pend_dm) && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
      if_flush  = 1'b0;
      dm_before = pend_dm;
      if (pend_dm) begin
        if (dm_done) begin
          chk("stall_mem_in_done", 32'(stall_mem), 32'd0);
          dm_req = 1'b0; pend_dm = 1'b0; done_cyc = cyc;
        end else chk("stall_mem_wait", 32'(stall_mem), 32'd1);
      end
      if (pend_if) begin
        if (mem_req && !dm_before) fcyc++;
        if (flush_at > 0) begin
          if (fcyc == flush_at) if_flush = 1'b1;
          if (mem_ready && !dm_before && fcyc > 0) begin if_req = 1'b0; pend_if = 1'b0; end
        end else if (if_done) begin
          if_req = 1'b0; pend_if = 1'b0; done_cyc = cyc;
        end else if (!dm_before) chk("stall_if_wait", 32'(stall_if), 32'd1);
      end
    end
    if (cyc >= 100) chk("access_timeout_cycles", 32'(cyc), 32'd99);
    else if (!(do_if && do_dm) && flush_at == 0)
      chk("done_latency", 32'(done_cyc), tmo ? 32'(TMO + 1) : 32'(l + 1));
    @(negedge clk); #2;
    if_flush = 1'b0; if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    issue_t is;
    reset = 1'b0;
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_done", {30'd0, if_done, dm_done}, 0);
    reset = 1'b1;
    @(negedge clk);

    ref_mem[4] = 32'h00500093;  env_mem[4] = 32'h00500093;
    ref_mem[65] = 32'h000000AB; env_mem[65] = 32'h000000AB;
    run_access(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    run_access(1, 1, 1, 32'h10, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    run_access(1, 0, 0, 32'h20, 0, 0, 0, 2, 0, 3);
    run_access(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 1);
    run_access(1, 0, 0, 32'h44, 0, 0, 0, 0, 1, 0);
    run_access(0, 1, 0, 0, 32'h104, 0, 4'h1, 0, 0, 1);
    run_access(1, 0, 0, 32'h24, 0, 0, 0, 3, 0, 2);
    run_access(0, 1, 1, 0, 32'h108, 32'h12345678, 4'h6, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 6);
      int l = $urandom_range(0, 3);
      logic [31:0] ia = 32'($urandom_range(0, 31)) << 2;
      logic [31:0] da = 32'($urandom_range(0, 31)) << 2;
      logic [31:0] wd = $urandom;
      logic [3:0]  ws = 4'($urandom_range(1, 15));
      case (kind)
        0: run_access(1, 0, 0, ia, da, wd, ws, 0, 0, l);
        1: run_access(0, 1, 0, ia, da, wd, ws, 0, 0, l);
        2: run_access(0, 1, 1, ia, da, wd, ws, 0, 0, l);
        3: run_access(1, 1, 1'($urandom_range(0, 1)), ia, da, wd, ws, 0, 0, l);
        4: run_access(1, 0, 0, ia, da, wd, ws, $urandom_range(1, l + 1), 0, l);
        5: run_access(1, 1, 0, ia, da, wd, ws, 0, 0, l);
        default: run_access(1'(n % 2), 1'(1 - n % 2), 1'($urandom_range(0, 1)), ia, da, wd, ws, 0, 1, 0);
      endcase
    end

    // Reset in the middle of a slow load; a stray ready afterwards must not complete anything.
    lat = 6; hang = 0;
    is = '{1'b0, 32'h80, 32'h0, 4'hF};
    issue_q.push_back(is);
    @(negedge clk); #2;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80; dm_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_mem_req", 32'(mem_req), 0);
    dm_req = 0; resp_en = 0; mem_ready = 0;
    @(negedge clk); #2;
    reset = 1'b1;
    @(negedge clk); #2;
    mem_ready = 1; mem_rdata = 32'h5555AAAA;
    #1;
    chk("late_ready_no_done", {30'd0, if_done, dm_done}, 0);
    @(negedge clk); #2;
    mem_ready = 0;
    repeat (3) @(negedge clk);
    #6;
    chk("issue_q_drained", 32'(issue_q.size()), 0);
    chk("if_q_drained", 32'(if_q.size()), 0);
    chk("dm_q_drained", 32'(dm_q.size()), 0);
    chk("bus_err_pulses", 32'(err_pulses), 32'(exp_err_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises accesses with a small FSM and gives data accesses fixed priority.
- Generates stall signals that hold the PC, IF_ID and the whole pipeline while an access is pending.
- Discards fetches killed by branch/jump flush and recovers from a hung memory with a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT, 255, cycles without mem_ready before an access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  branch/jump redirect; kills the in-flight fetch.
- if_done  out  1  fetch complete; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request; level, held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_wstrb  in  DATA_W/8  byte enables (from funct3).
- dm_done  out  1  data access complete; dm_rdata valid this cycle.
- dm_rdata  out  DATA_W  load data.
- mem_req  out  1  memory access strobe (registered).
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_wstrb  out  DATA_W/8  registered byte enables.
- mem_ready  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- stall_if  out  1  hold PC and IF_ID.
- stall_mem  out  1  hold all pipeline registers.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err, drop flag and timeout counter all 0.
  - Consequently if_done=dm_done=0.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - dm_req=1 -> DATA. Latch dm_we/addr/wdata/wstrb into the mem_* registers and set mem_req=1 on the next edge.
  - Otherwise if_req=1 -> FETCH. Latch if_addr, set mem_we=0, mem_wstrb=0, mem_req=1.
  - mem_ready is ignored in IDLE.
- Priority: when both requests are asserted in the same IDLE cycle, data wins and the fetch waits.
- FETCH/DATA:
  - mem_req and the mem_* registers are held until mem_ready=1 is sampled.
  - On that edge: mem_req=0 and the FSM returns to IDLE.
  - No back-to-back issue without an IDLE cycle in between.
- Completion is combinational:
  - if_done = (state==FETCH) & mem_ready & ~drop.
  - dm_done = (state==DATA) & mem_ready.
  - rdata outputs pass mem_rdata through.
  - Minimum access time is 2 cycles (IDLE issue + zero-wait ready).
- Stalls (combinational):
  - stall_mem = dm_req & ~dm_done.
  - stall_if = (if_req & ~if_done) | stall_mem.
- Flush:
  - if_flush in FETCH sets drop; the completing mem_ready then produces no if_done.
  - if_flush in the same cycle as mem_ready also suppresses if_done.
  - drop clears on leaving FETCH.
  - if_flush in IDLE or DATA has no effect.
- Requester changes mid-access: the latched values are used. Deasserting a req or changing the address before done is ignored; the access completes.
- Timeout (TIMEOUT>0):
  - The counter clears on entering FETCH/DATA and increments each cycle mem_ready=0.
  - When the count equals TIMEOUT: bus_err=1 for one cycle, mem_req=0, return to IDLE.
  - Fetch aborted by timeout: if_done=1 with if_rdata=32'h00000013 (NOP), unless drop is set.
  - Data aborted by timeout: dm_done=1 with dm_rdata=0.
  - mem_ready arriving in the timeout cycle takes precedence; no error is raised.
- Reset mid-access: mem_req drops immediately (asynchronously); a late mem_ready is ignored in IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, FETCH=2'd1, DATA=2'd2.
  - NOP_INST = 32'h00000013.
  - the default TIMEOUT.
- One sub-module, mem_timeout_ctr: counter with clear/enable inputs and an expire output, parameterised by TIMEOUT.

Test Plan:
- Fetch, zero-wait: if_req=1, if_addr=0x00000010, mem_ready one cycle after mem_req with mem_rdata=0x00500093. Expect mem_addr=0x10, mem_we=0; if_done=1 with if_rdata=0x00500093 two cycles after the request; stall_if=1 only in the first cycle.
- Simultaneous requests: if_req=1 and dm_req=1 (store to 0x100, wdata=0xDEADBEEF, wstrb=4'hF) in the same cycle, 2-cycle memory. Expect DATA issued first with mem_we=1 and stall_mem=1 until dm_done; FETCH issued after the next IDLE cycle.
- Flush in flight: FETCH at 0x20, if_flush pulsed while waiting, mem_ready 3 cycles later. Expect no if_done and state back to IDLE; a new fetch at 0x40 then completes normally.
- Timeout: TIMEOUT=8, fetch issued and mem_ready never asserted. Expect bus_err pulse after 8 wait cycles, if_done=1 with if_rdata=0x00000013, mem_req=0.
- Load with byte strobe: dm_req load from 0x104, mem_rdata=0x000000AB after 1 wait cycle. Expect dm_done with dm_rdata=0xAB and stall_mem deasserting in the dm_done cycle.
- Asynchronous reset mid-DATA: assert reset=0 between edges. Expect mem_req=0 immediately and a subsequent mem_ready pulse producing no done.
